// File: rtl/spi_pixel_master.sv
// SPI mode-0 transmitter: streams BITS_PER_PIXEL-wide pixel words MSB first,
// with back-to-back words sharing a gapless spi_clk.
module spi_pixel_master #(
    parameter int BITS_PER_PIXEL = 32,
    parameter int HALF_PERIOD    = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [BITS_PER_PIXEL-1:0] in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      spi_clk,
    output logic                      spi_mosi,
    output logic                      busy,
    output logic                      word_done
);

    localparam int HW = $clog2(HALF_PERIOD + 1);
    localparam int BW = $clog2(BITS_PER_PIXEL + 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(HALF_PERIOD - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(BITS_PER_PIXEL - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOW  = 2'd1;
    localparam logic [1:0] HIGH = 2'd2;

    logic [1:0]                state;
    logic [HW-1:0]             half_cnt;
    logic [BW-1:0]             bit_cnt;
    logic [BITS_PER_PIXEL-1:0] shift_reg;
    logic                      half_end;
    logic                      last_bit;
    logic                      accept;

    assign half_end = (half_cnt == HALF_LAST);
    assign last_bit = (bit_cnt == BIT_LAST);

    // Ready in IDLE, or on the very last clk of the final bit so the next word
    // is loaded on the same edge that ends the current one.
    assign in_ready = !reset &&
                      ((state == IDLE) || ((state == HIGH) && half_end && last_bit));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            half_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            spi_clk   <= 1'b0;
            spi_mosi  <= 1'b0;
            busy      <= 1'b0;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift_reg <= in_data;
                        bit_cnt   <= '0;
                        half_cnt  <= '0;
                        spi_mosi  <= in_data[BITS_PER_PIXEL-1];
                        busy      <= 1'b1;
                        state     <= LOW;
                    end
                end
                LOW: begin
                    if (half_end) begin
                        half_cnt <= '0;
                        spi_clk  <= 1'b1;
                        state    <= HIGH;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (!half_end) begin
                        half_cnt <= half_cnt + 1'b1;
                    end else begin
                        half_cnt <= '0;
                        spi_clk  <= 1'b0;
                        if (!last_bit) begin
                            shift_reg <= shift_reg << 1;
                            spi_mosi  <= shift_reg[BITS_PER_PIXEL-2];
                            bit_cnt   <= bit_cnt + 1'b1;
                            state     <= LOW;
                        end else begin
                            word_done <= 1'b1;
                            if (accept) begin
                                shift_reg <= in_data;
                                bit_cnt   <= '0;
                                spi_mosi  <= in_data[BITS_PER_PIXEL-1];
                                state     <= LOW;
                            end else begin
                                spi_mosi <= 1'b0;
                                busy     <= 1'b0;
                                state    <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    spi_clk  <= 1'b0;
                    spi_mosi <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_pixel_master.sv
// Bench for spi_pixel_master: two instances (HALF_PERIOD 1 and 3) checked every
// cycle against a word-position model, plus a receiver that rebuilds the words.
module tb_spi_pixel_master;

    logic        clk;
    logic        reset;
    logic [31:0] in_data  [2];
    logic        in_valid [2];
    logic        in_ready [2];
    logic        spi_clk  [2];
    logic        spi_mosi [2];
    logic        busy     [2];
    logic        word_done[2];

    int checks   = 0;
    int failures = 0;

    spi_pixel_master #(.BITS_PER_PIXEL(32), .HALF_PERIOD(1)) dut_hp1 (
        .clk(clk), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .spi_clk(spi_clk[0]), .spi_mosi(spi_mosi[0]),
        .busy(busy[0]), .word_done(word_done[0])
    );

    spi_pixel_master #(.BITS_PER_PIXEL(32), .HALF_PERIOD(3)) dut_hp3 (
        .clk(clk), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .spi_clk(spi_clk[1]), .spi_mosi(spi_mosi[1]),
        .busy(busy[1]), .word_done(word_done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int hp(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Reference model: a word occupies positions k = 0 .. 64*hp-1 after its accept.
    bit          m_active[2];
    int          m_k[2];
    logic [31:0] m_word[2];
    bit          m_done[2];
    int          done_exp[2];
    int          rise_exp[2];
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    int          done_obs[2];
    int          rise_obs[2];
    bit          prev_clk[2];
    int          rx_cnt[2];
    logic [31:0] rx_sh[2];

    task automatic model_step(input int d);
        int  w;
        bit  rdy;
        bit  acc;
        w = 64 * hp(d);
        if (reset) begin
            if (m_active[d]) begin
                if (d == 0 && q0.size() > 0) void'(q0.pop_back());
                if (d == 1 && q1.size() > 0) void'(q1.pop_back());
            end
            m_active[d] = 1'b0;
            m_done[d]   = 1'b0;
        end else begin
            rdy = !m_active[d] || (m_k[d] == w - 1);
            acc = in_valid[d] && rdy;
            m_done[d] = m_active[d] && (m_k[d] == w - 1);
            if (m_done[d]) done_exp[d]++;
            if (m_active[d] && m_k[d] < w - 1) begin
                m_k[d]++;
            end else if (acc) begin
                m_active[d] = 1'b1;
                m_k[d]      = 0;
                m_word[d]   = in_data[d];
                if (d == 0) q0.push_back(in_data[d]);
                else        q1.push_back(in_data[d]);
            end else begin
                m_active[d] = 1'b0;
            end
            if (m_active[d] && (m_k[d] % (2 * hp(d)) == hp(d))) rise_exp[d]++;
        end
    endtask

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) model_step(d);
    end

    task automatic cycle_check(input int d);
        int          h;
        int          k;
        logic        e_clk;
        logic        e_mosi;
        logic        e_rdy;
        logic [31:0] e_word;
        h = hp(d);
        k = m_k[d];
        e_clk  = m_active[d] && ((k % (2 * h)) >= h);
        e_mosi = m_active[d] ? m_word[d][31 - k / (2 * h)] : 1'b0;
        e_rdy  = !reset && (!m_active[d] || k == 64 * h - 1);
        check($sformatf("spi_clk[%0d]", d),   32'(spi_clk[d]),   32'(e_clk));
        check($sformatf("spi_mosi[%0d]", d),  32'(spi_mosi[d]),  32'(e_mosi));
        check($sformatf("busy[%0d]", d),      32'(busy[d]),      32'(m_active[d]));
        check($sformatf("word_done[%0d]", d), 32'(word_done[d]), 32'(m_done[d]));
        check($sformatf("in_ready[%0d]", d),  32'(in_ready[d]),  32'(e_rdy));

        // Receiver: sample mosi on each spi_clk rising edge.
        if (spi_clk[d] && !prev_clk[d]) rise_obs[d]++;
        if (word_done[d]) done_obs[d]++;
        if (reset) begin
            rx_cnt[d] = 0;
        end else if (spi_clk[d] && !prev_clk[d]) begin
            rx_sh[d] = {rx_sh[d][30:0], spi_mosi[d]};
            rx_cnt[d]++;
            if (rx_cnt[d] == 32) begin
                rx_cnt[d] = 0;
                if (d == 0) e_word = (q0.size() > 0) ? q0.pop_front() : 32'hxxxx_xxxx;
                else        e_word = (q1.size() > 0) ? q1.pop_front() : 32'hxxxx_xxxx;
                check($sformatf("rx_word[%0d]", d), rx_sh[d], e_word);
            end
        end
        prev_clk[d] = spi_clk[d];
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) cycle_check(d);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic [31:0] w);
        bit rdy;
        int n;
        n = 0;
        in_data[d]  = w;
        in_valid[d] = 1'b1;
        do begin
            @(negedge clk);
            rdy = in_ready[d];
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 2000);
        if (!rdy) check($sformatf("handshake_timeout[%0d]", d), 32'd0, 32'd1);
    endtask

    task automatic rand_traffic(input int d, input int words);
        int gap;
        for (int i = 0; i < words; i++) begin
            send(d, $urandom);
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                in_valid[d] = 1'b0;
                for (int g = 0; g < gap * 20; g++) begin
                    in_data[d] = $urandom;
                    step(1);
                end
            end
        end
        in_valid[d] = 1'b0;
    endtask

    int done_base;

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b1;
            in_data[d]  = $urandom;
        end
        step(4);
        reset = 1'b0;
        in_valid[0] = 1'b0;
        in_valid[1] = 1'b0;
        step(2);

        // Three-word stream, valid held throughout.
        done_base = done_obs[0];
        send(0, 32'hdeadbeef);
        send(0, 32'hcabba6e0);
        send(0, 32'h00000000);
        in_valid[0] = 1'b0;
        step(70);
        check("stream_word_done_count", 32'(done_obs[0] - done_base), 32'd3);

        send(0, 32'h80000001);
        in_valid[0] = 1'b0;
        step(70);

        send(1, 32'ha5a5a5a5);
        in_valid[1] = 1'b0;
        step(200);

        // Valid held high across several words.
        in_valid[0] = 1'b1;
        for (int i = 0; i < 4; i++) send(0, $urandom);
        in_valid[0] = 1'b0;
        step(70);

        // Reset at bit 10 of an all-ones word, then a fresh word.
        send(0, 32'hffffffff);
        in_valid[0] = 1'b0;
        step(20);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(3);
        send(0, 32'h12345678);
        in_valid[0] = 1'b0;
        step(70);

        fork
            rand_traffic(0, 25);
            rand_traffic(1, 8);
        join
        step(400);

        for (int d = 0; d < 2; d++) begin
            check($sformatf("word_done_total[%0d]", d), 32'(done_obs[d]), 32'(done_exp[d]));
            check($sformatf("rise_total[%0d]", d),      32'(rise_obs[d]), 32'(rise_exp[d]));
            check($sformatf("rx_partial[%0d]", d),      32'(rx_cnt[d]),   32'd0);
        end
        check("rx_pending[0]", 32'(q0.size()), 32'd0);
        check("rx_pending[1]", 32'(q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
